alu16_seq: RTL and testbench



---
 rtl/alu16_seq_if.sv | 60 ++++++
 rtl/alu16_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu16_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_seq_if.sv
// ============================================================================
// alu16_seq_if
// ----------------------------------------------------------------------------
// Request/response bundle between the execute-stage issue logic and the
// 16-bit arithmetic sequencer alu16_seq.
//
// Signals:
//   start  - request, only honoured while ready is high
//   op     - 00 ADD, 01 ADC, 10 SBC, 11 reserved (treated as ADD)
//   x      - first operand (HL)
//   y      - second operand (rr)
//   f_in   - current F register, bit order S Z 5 H 3 V N C
//   ready  - sequencer idle and able to accept a start
//   done   - one-cycle pulse marking out/f as freshly valid
//   out    - registered 16-bit result
//   f      - registered flags, same bit order as f_in
//
// Modports:
//   master - the requester (drives start/op/x/y/f_in)
//   slave  - the sequencer (drives ready/done/out/f)
// ============================================================================
interface alu16_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  f_in;
    logic        ready;
    logic        done;
    logic [15:0] out;
    logic [7:0]  f;

    // Requester view: drives the operation, observes the result.
    modport master (
        output start,
        output op,
        output x,
        output y,
        output f_in,
        input  ready,
        input  done,
        input  out,
        input  f
    );

    // Sequencer view: consumes the operation, produces the result.
    modport slave (
        input  start,
        input  op,
        input  x,
        input  y,
        input  f_in,
        output ready,
        output done,
        output out,
        output f
    );

endinterface

// File: rtl/alu16_seq.sv
// ============================================================================
// alu16_seq
// ----------------------------------------------------------------------------
// Two-cycle sequencer for the Z80 16-bit arithmetic group (ADD HL,rr;
// ADC HL,rr; SBC HL,rr). The low byte and then the high byte pass through a
// single 8-bit add/subtract datapath, with the carry/borrow out of bit 7
// chained into the high-byte pass.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous, active-low reset
//   bus      - alu16_seq_if.slave: start/op/x/y/f_in in, ready/done/out/f out
//
// Timing: start sampled at edge E0 (IDLE->LO), low byte computed at E1
// (LO->HI), out/f/done registered at E2 (HI->IDLE). ready is high in IDLE,
// including the done cycle, so a new request can follow with no bubble.
//
// Optional feature:
//   ALU16_SEQ_UNDOC_FLAGS_EN - when defined, f[5]=out[13] and f[3]=out[11]
//   (real Z80 undocumented flag behaviour). When undefined, f[5] and f[3]
//   pass through the latched f_in[5] and f_in[3].
// ============================================================================
module alu16_seq (
    input  logic       clk,
    input  logic       reset_n,
    alu16_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  f_in_q, f_in_d;

    logic [7:0]  lo_q, lo_d;
    logic        chain_q, chain_d;

    logic [15:0] out_q, out_d;
    logic [7:0]  f_q, f_d;
    logic        done_q, done_d;

    logic        is_adc;
    logic        is_sbc;
    logic [7:0]  dp_a;
    logic [7:0]  dp_b;
    logic [7:0]  dp_b_eff;
    logic        dp_chain_in;
    logic        dp_cin;
    logic [8:0]  dp_sum;
    logic        dp_chain_out;
    logic        dp_half_out;
    logic        dp_ovf;

    logic [15:0] result;
    logic [7:0]  new_f;

    // Shared 8-bit datapath. Subtraction is done as a + ~b + ~borrow_in, so
    // the raw adder carry is the inverse of the borrow. The chain flop and
    // the H/C flags always hold the Z80 sense (carry for add, borrow for
    // subtract), hence the XOR with is_sbc on the way in and on the way out.
    // The half-carry into bit 4 of the byte is recovered from the sum bit
    // without a separate nibble adder; in the high pass that bit is bit 12.
    always_comb begin
        is_adc = (op_q == 2'b01);
        is_sbc = (op_q == 2'b10);

        if (state_q == HI) begin
            dp_a        = x_q[15:8];
            dp_b        = y_q[15:8];
            dp_chain_in = chain_q;
        end else begin
            dp_a        = x_q[7:0];
            dp_b        = y_q[7:0];
            dp_chain_in = (is_adc | is_sbc) & f_in_q[0];
        end

        dp_b_eff     = dp_b ^ {8{is_sbc}};
        dp_cin       = dp_chain_in ^ is_sbc;
        dp_sum       = {1'b0, dp_a} + {1'b0, dp_b_eff} + {8'b0, dp_cin};
        dp_chain_out = dp_sum[8] ^ is_sbc;
        dp_half_out  = dp_sum[4] ^ dp_a[4] ^ dp_b_eff[4] ^ is_sbc;
        dp_ovf       = (dp_a[7] == dp_b_eff[7]) && (dp_sum[7] != dp_a[7]);
    end

    // Final 16-bit result and flag byte, only meaningful during HI. ADD
    // leaves S, Z and V untouched, while ADC/SBC derive them from the full
    // 16-bit result. V from the high pass equals the 16-bit signed overflow
    // because ~y is exactly -y-1 and never overflows on its own.
    always_comb begin
        result = {dp_sum[7:0], lo_q};

        new_f    = 8'h00;
        new_f[4] = dp_half_out;
        new_f[1] = is_sbc;
        new_f[0] = dp_chain_out;

        if (is_adc || is_sbc) begin
            new_f[7] = result[15];
            new_f[6] = (result == 16'h0000);
            new_f[2] = dp_ovf;
        end else begin
            new_f[7] = f_in_q[7];
            new_f[6] = f_in_q[6];
            new_f[2] = f_in_q[2];
        end

`ifdef ALU16_SEQ_UNDOC_FLAGS_EN
        new_f[5] = result[13];
        new_f[3] = result[11];
`else
        new_f[5] = f_in_q[5];
        new_f[3] = f_in_q[3];
`endif
    end

    // The incoming H and N bits are always recomputed, so they are never
    // read from the latched F. With undocumented flags on, bits 5 and 3 are
    // taken from the result instead of the latched F as well.
`ifdef ALU16_SEQ_UNDOC_FLAGS_EN
    logic unused_f_in_bits;
    assign unused_f_in_bits = ^{f_in_q[5], f_in_q[4], f_in_q[3], f_in_q[1]};
`else
    logic unused_f_in_bits;
    assign unused_f_in_bits = ^{f_in_q[4], f_in_q[1]};
`endif

    // Next-state and register updates. Operands are only captured on an
    // accepted start, so anything presented while busy is simply ignored
    // and the operation in flight keeps its own copy. out and f only change
    // at the end of an operation and otherwise hold.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        f_in_d  = f_in_q;
        lo_d    = lo_q;
        chain_d = chain_q;
        out_d   = out_q;
        f_d     = f_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    op_d    = bus.op;
                    f_in_d  = bus.f_in;
                    state_d = LO;
                end
            end
            LO: begin
                lo_d    = dp_sum[7:0];
                chain_d = dp_chain_out;
                state_d = HI;
            end
            HI: begin
                out_d   = result;
                f_d     = new_f;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset drops any operation in progress back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches, low-byte pipeline and result registers. Clearing out,
    // f and done here means an abandoned operation leaves no trace.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= 16'h0000;
            y_q     <= 16'h0000;
            op_q    <= 2'b00;
            f_in_q  <= 8'h00;
            lo_q    <= 8'h00;
            chain_q <= 1'b0;
            out_q   <= 16'h0000;
            f_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            f_in_q  <= f_in_d;
            lo_q    <= lo_d;
            chain_q <= chain_d;
            out_q   <= out_d;
            f_q     <= f_d;
            done_q  <= done_d;
        end
    end

    // ready follows IDLE directly, so it is high again in the done cycle.
    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.f     = f_q;

endmodule

// File: tb/tb_alu16_seq.sv
// ============================================================================
// tb_alu16_seq
// ----------------------------------------------------------------------------
// Self-checking bench for alu16_seq. Table of vectors with hand-derived
// results plus hand-written handshake and reset sequences. Expected results
// are queued when a request is driven and compared when done pulses.
// ============================================================================
module tb_alu16_seq;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  f_in;
        logic [15:0] exp_out;
        logic [7:0]  exp_f;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [7:0]  f;
    } exp_t;

    localparam int NV = 11;

    logic   clk;
    logic   reset_n;
    int     total;
    int     bad;
    int     cyc;
    vec_t   vecs [NV];
    exp_t   sb_q [$];

    alu16_seq_if bus ();

    alu16_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog");
    end

    // Table values are written for the default build; with undocumented
    // flags on, bits 5 and 3 follow result bits 13 and 11 instead.
    function automatic logic [7:0] adjF(input logic [7:0] fv, input logic [15:0] ov);
        logic [7:0] r;
        r = fv;
`ifdef ALU16_SEQ_UNDOC_FLAGS_EN
        r[5] = ov[13];
        r[3] = ov[11];
`endif
        return r;
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Drive one request for a cycle from a point just after a rising edge,
    // queue its expected result, then scramble the inputs so the operation
    // in flight must rely on its own latched copy.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] xv,
                                 input logic [15:0] yv, input logic [7:0] fv,
                                 input logic [15:0] eo, input logic [7:0] ef);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = xv;
        bus.y     = yv;
        bus.f_in  = fv;
        e.out     = eo;
        e.f       = adjF(ef, eo);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.x     = 16'($urandom);
        bus.y     = 16'($urandom);
        bus.f_in  = 8'($urandom);
    endtask

    // Count edges until done is seen, giving up after a bounded wait.
    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.done && cycles < 8);
    endtask

    // Scoreboard: every done pulse must match the oldest queued result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got done=1, want done=0");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_out", bus.out, e.out);
                    checkOutput("sb_f", {8'h00, bus.f}, {8'h00, e.f});
                end
            end
        end
    end

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.x     = 16'h0000;
        bus.y     = 16'h0000;
        bus.f_in  = 8'h00;
        reset_n   = 1'b1;

        vecs[0]  = '{2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4};
        vecs[1]  = '{2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94};
        vecs[2]  = '{2'b10, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'h93};
        vecs[3]  = '{2'b10, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42};
        vecs[4]  = '{2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h11};
        vecs[5]  = '{2'b11, 16'h8000, 16'h8000, 8'hFF, 16'h0000, 8'hED};
        vecs[6]  = '{2'b01, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h45};
        vecs[7]  = '{2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h16};
        vecs[8]  = '{2'b01, 16'h1234, 16'h4321, 8'h01, 16'h5556, 8'h00};
        vecs[9]  = '{2'b00, 16'h0001, 16'h0002, 8'h28, 16'h0003, 8'h28};
        vecs[10] = '{2'b00, 16'h2800, 16'h0000, 8'h00, 16'h2800, 8'h00};

        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_ready", {15'h0, bus.ready}, 16'h0001);
        checkOutput("reset_done", {15'h0, bus.done}, 16'h0000);
        checkOutput("reset_out", bus.out, 16'h0000);
        checkOutput("reset_f", {8'h00, bus.f}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].f_in,
                          vecs[i].exp_out, vecs[i].exp_f);
            checkOutput($sformatf("vec%0d_ready_busy", i), {15'h0, bus.ready}, 16'h0000);
            waitDone(cyc);
            checkOutput($sformatf("vec%0d_latency", i), 16'(cyc), 16'd2);
            checkOutput($sformatf("vec%0d_ready_done", i), {15'h0, bus.ready}, 16'h0001);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_drop", i), {15'h0, bus.done}, 16'h0000);
            checkOutput($sformatf("vec%0d_out_hold", i), bus.out, vecs[i].exp_out);
        end

        // Back-to-back: second request presented during the done cycle.
        applyStimulus(2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94);
        waitDone(cyc);
        checkOutput("b2b_first_latency", 16'(cyc), 16'd2);
        applyStimulus(2'b10, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42);
        checkOutput("b2b_accepted", {15'h0, bus.ready}, 16'h0000);
        waitDone(cyc);
        checkOutput("b2b_second_latency", 16'(cyc), 16'd2);

        // Start pulsed while in LO with other operands must be ignored.
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.x     = 16'hAAAA;
        bus.y     = 16'h5555;
        bus.f_in  = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(cyc);
        checkOutput("ignored_start_latency", 16'(cyc), 16'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("ignored_start_no_done%0d", k), {15'h0, bus.done}, 16'h0000);
        end

        // Reset during HI of an ADD: immediate clear, no done afterwards.
        applyStimulus(2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        checkOutput("midreset_out", bus.out, 16'h0000);
        checkOutput("midreset_f", {8'h00, bus.f}, 16'h0000);
        checkOutput("midreset_ready", {15'h0, bus.ready}, 16'h0001);
        checkOutput("midreset_done", {15'h0, bus.done}, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midreset_no_done%0d", k), {15'h0, bus.done}, 16'h0000);
        end

        // Recovery after the abandoned operation.
        applyStimulus(2'b10, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'h93);
        waitDone(cyc);
        checkOutput("recover_latency", 16'(cyc), 16'd2);
        @(posedge clk);
        #1;

        checkOutput("scoreboard_empty", 16'(sb_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
